// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: instruction word layout,
// stored entry format and the operand wakeup helper.
package rs_pkg;

  localparam int INST_W        = 116;
  localparam int TAG_W         = 5;
  localparam int DEFAULT_DEPTH = 4;

  // Field offsets inside the decomposed instruction word
  localparam int MEMDATA_LSB  = 84;
  localparam int MEMDATA_W    = 32;
  localparam int CTRL_LSB     = 71;
  localparam int CTRL_W       = 13;
  localparam int RS2_VT_LSB   = 39;
  localparam int S2_VALID_BIT = 38;
  localparam int RS1_VT_LSB   = 6;
  localparam int S1_VALID_BIT = 5;
  localparam int RD_LSB       = 0;
  localparam int RD_W         = 5;
  localparam int VT_W         = 32;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Capture a broadcast result into any pending operand whose tag matches.
  // Tag 0 is the hard-wired zero register and is never a pending tag.
  function automatic logic [INST_W-1:0] wake_operands(
    input logic [INST_W-1:0] inst,
    input logic [TAG_W-1:0]  rs1_tag,
    input logic [TAG_W-1:0]  rs2_tag,
    input logic              bus_valid,
    input logic [TAG_W-1:0]  bus_tag,
    input logic [VT_W-1:0]   bus_data
  );
    logic [INST_W-1:0] w;
    w = inst;
    if (bus_valid && (bus_tag != {TAG_W{1'b0}})) begin
      if (!inst[S1_VALID_BIT] && (rs1_tag == bus_tag)) begin
        w[S1_VALID_BIT]            = 1'b1;
        w[RS1_VT_LSB +: VT_W]      = bus_data;
      end
      if (!inst[S2_VALID_BIT] && (rs2_tag == bus_tag)) begin
        w[S2_VALID_BIT]            = 1'b1;
        w[RS2_VT_LSB +: VT_W]      = bus_data;
        w[MEMDATA_LSB +: MEMDATA_W] = bus_data;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Handshake, result-bus and issue signals of the reservation station.
// slave: the station's view; master: the surrounding pipeline's view.
interface reservation_station_if #(
  parameter int DEPTH  = rs_pkg::DEFAULT_DEPTH,
  parameter int TAG_W  = rs_pkg::TAG_W,
  parameter int INST_W = rs_pkg::INST_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [TAG_W-1:0]  in_rs1_tag;
  logic [TAG_W-1:0]  in_rs2_tag;
  logic              flush;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_inst, in_rs1_tag, in_rs2_tag, flush,
    input  cdb_valid, cdb_tag, cdb_data, out_ready,
    output in_ready, out_valid, out_inst, count
  );

  modport master (
    output in_valid, in_inst, in_rs1_tag, in_rs2_tag, flush,
    output cdb_valid, cdb_tag, cdb_data, out_ready,
    input  in_ready, out_valid, out_inst, count
  );

endinterface

// File: rtl/reservation_station_oldest_ready_select.sv
// Picks the ready entry with the largest age (oldest) and returns a one-hot
// grant. Ages of valid entries are unique, so no tie-break is needed.
module rs_oldest_ready_select #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        found_o
);

  logic [AGE_W-1:0] best_age_s;

  // Linear scan keeping the oldest ready candidate seen so far
  always_comb begin
    grant_o    = {DEPTH{1'b0}};
    found_o    = 1'b0;
    best_age_s = {AGE_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_i[i] && (!found_o || (age_i[i] > best_age_s))) begin
        grant_o    = {DEPTH{1'b0}};
        grant_o[i] = 1'b1;
        found_o    = 1'b1;
        best_age_s = age_i[i];
      end else begin
        best_age_s = best_age_s;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds decomposed instructions until both operands are
// valid, snoops the result bus for wakeups and issues the oldest ready entry.
// Optional macro RS_ALLOC_WAKEUP_EN: an incoming word also captures a
// same-cycle result-bus match while being allocated.
module reservation_station #(
  parameter int DEPTH  = rs_pkg::DEFAULT_DEPTH,
  parameter int TAG_W  = rs_pkg::TAG_W,
  parameter int INST_W = rs_pkg::INST_W
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave bus
);
  import rs_pkg::*;

  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = AGE_W + 1;

  entry_t                      ent_q [DEPTH];
  entry_t                      ent_d [DEPTH];
  logic [DEPTH-1:0][AGE_W-1:0] age_q, age_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic [DEPTH-1:0]  ready_s, grant_s;
  logic              found_s, alloc_s, issue_s, in_ready_s;
  logic [AGE_W-1:0]  issue_age_s, free_idx_s;
  logic [INST_W-1:0] out_inst_s, alloc_inst_s;

  // An entry is ready once both source operands carry values
  always_comb begin
    ready_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = ent_q[i].valid & ent_q[i].inst[S1_VALID_BIT] & ent_q[i].inst[S2_VALID_BIT];
    end
  end

  rs_oldest_ready_select #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_select (
    .ready_i (ready_s),
    .age_i   (age_q),
    .grant_o (grant_s),
    .found_o (found_s)
  );

  // One-hot mux of the granted word and its age; all-zero when nothing is ready
  always_comb begin
    out_inst_s  = {INST_W{1'b0}};
    issue_age_s = {AGE_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      out_inst_s  = out_inst_s | ({INST_W{grant_s[i]}} & ent_q[i].inst);
      issue_age_s = issue_age_s | ({AGE_W{grant_s[i]}} & age_q[i]);
    end
  end

  // Lowest-index free slot, scanned from the top so the lowest index wins
  always_comb begin
    free_idx_s = {AGE_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = ent_q[i].valid ? free_idx_s : AGE_W'(i);
    end
  end

  // in_ready looks only at the registered count, never at out_ready
  assign in_ready_s = (count_q < CNT_W'(DEPTH));
  assign alloc_s    = bus.in_valid & in_ready_s & ~bus.flush;
  assign issue_s    = found_s & bus.out_ready & ~bus.flush;

`ifdef RS_ALLOC_WAKEUP_EN
  assign alloc_inst_s = wake_operands(bus.in_inst, bus.in_rs1_tag, bus.in_rs2_tag,
                                      bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`else
  assign alloc_inst_s = bus.in_inst;
`endif

  // Next state: flush wins; otherwise wakeup, free the issued entry, re-rank
  // survivors (decrement above the issued age, then increment on allocation)
  // and write the new word at age 0
  always_comb begin
    ent_d   = ent_q;
    age_d   = age_q;
    count_d = count_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        age_d[i]       = {AGE_W{1'b0}};
      end
      count_d = {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].inst = wake_operands(ent_q[i].inst, ent_q[i].rs1_tag, ent_q[i].rs2_tag,
                                      bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        if (issue_s && grant_s[i]) begin
          ent_d[i].valid = 1'b0;
        end else begin
          ent_d[i].valid = ent_q[i].valid;
        end
        age_d[i] = age_q[i] - AGE_W'(issue_s && (age_q[i] > issue_age_s)) + AGE_W'(alloc_s);
      end
      if (alloc_s) begin
        ent_d[free_idx_s].valid   = 1'b1;
        ent_d[free_idx_s].inst    = alloc_inst_s;
        ent_d[free_idx_s].rs1_tag = bus.in_rs1_tag;
        ent_d[free_idx_s].rs2_tag = bus.in_rs2_tag;
        age_d[free_idx_s]         = {AGE_W{1'b0}};
      end else begin
        ent_d[free_idx_s] = ent_d[free_idx_s];
      end
      count_d = count_q + CNT_W'(alloc_s) - CNT_W'(issue_s);
    end
  end

  // Entry, age and occupancy registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      age_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = found_s;
  assign bus.out_inst  = out_inst_s;
  assign bus.count     = count_q;

endmodule
